// File: rtl/ysyx_24110006_trap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24110006_trap_pkg
//  Purpose  : Shared definitions for the trap/CSR sequencer: op codes, CSR
//             addresses, mstatus bit positions, trap cause codes and the
//             sequencer state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ysyx_24110006_trap_pkg;

   typedef enum logic [2:0] {
      OP_NONE   = 3'd0,
      OP_CSRRW  = 3'd1,
      OP_CSRRS  = 3'd2,
      OP_CSRRC  = 3'd3,
      OP_ECALL  = 3'd4,
      OP_EBREAK = 3'd5,
      OP_MRET   = 3'd6
   } op_e;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [4:0] CAUSE_ECALL_M    = 5'd11;
   localparam logic [4:0] CAUSE_BREAKPOINT = 5'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_WR    = 3'd2,
      S_EPC   = 3'd3,
      S_CAUSE = 3'd4,
      S_STAT  = 3'd5,
      S_VEC   = 3'd6,
      S_RESP  = 3'd7
   } state_e;

   // Read-only identification CSRs: the CSR file returns a constant for
   // these and discards writes, so the sequencer does not special-case them.
   function automatic logic csr_is_read_only(input logic [11:0] addr);
      return (addr == CSR_MVENDORID) || (addr == CSR_MARCHID);
   endfunction

endpackage : ysyx_24110006_trap_pkg
`default_nettype wire

// File: rtl/ysyx_24110006_csr_alu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24110006_csr_alu
//  Purpose  : Combinational new-value generator for CSR writes: csrrw/s/c
//             data merge, and mstatus update for trap entry and mret.
//  Ports    : op      in  3     operation (ysyx_24110006_trap_pkg::op_e)
//             old_val in  XLEN  current CSR value
//             src     in  XLEN  rs1 value / zimm
//             new_val out XLEN  value to write back
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_24110006_csr_alu
   import ysyx_24110006_trap_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] src,
   output logic [XLEN-1:0] new_val
);

   always_comb begin
      new_val = old_val;
      case (op)
         OP_CSRRW: new_val = src;
         OP_CSRRS: new_val = old_val | src;
         OP_CSRRC: new_val = old_val & ~src;
         OP_ECALL, OP_EBREAK: begin
            // Trap entry: stash the interrupt enable, mask interrupts, M-mode.
            new_val[MSTATUS_MPIE]                  = old_val[MSTATUS_MIE];
            new_val[MSTATUS_MIE]                   = 1'b0;
            new_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
         end
         OP_MRET: begin
            // Trap return: restore MIE; only M-mode exists so MPP stays 11.
            new_val[MSTATUS_MIE]                   = old_val[MSTATUS_MPIE];
            new_val[MSTATUS_MPIE]                  = 1'b1;
            new_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
         end
         default: new_val = old_val;
      endcase
   end

endmodule : ysyx_24110006_csr_alu
`default_nettype wire

// File: rtl/ysyx_24110006_trap_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24110006_trap_unit
//  Purpose  : Sequences CSR instructions and ecall/ebreak/mret from EXU into
//             at most one CSR-file write per cycle, returning the old CSR
//             value and, for traps/mret, a redirect PC.
//  Ports    : i_clock, i_reset            clock, sync active-high reset
//             i_valid/o_ready             request handshake (ready in IDLE)
//             i_op, i_csr_addr, i_src,
//             i_src_zero, i_pc            request payload
//             o_resp_valid/i_resp_ready   response handshake
//             o_rd_data, o_redirect,
//             o_redirect_pc               response payload (registered)
//             o_csr_wen, o_csr_addr,
//             o_csr_wdata, i_csr_rdata    CSR file port (comb. read)
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_24110006_trap_unit
   import ysyx_24110006_trap_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] MTVEC_MASK = 32'hFFFF_FFFC
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_op,
   input  logic [11:0]     i_csr_addr,
   input  logic [XLEN-1:0] i_src,
   input  logic            i_src_zero,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_resp_valid,
   input  logic            i_resp_ready,
   output logic [XLEN-1:0] o_rd_data,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_redirect_pc,
   output logic            o_csr_wen,
   output logic [11:0]     o_csr_addr,
   output logic [XLEN-1:0] o_csr_wdata,
   input  logic [XLEN-1:0] i_csr_rdata
);

   state_e          state;
   logic [2:0]      op_q;
   logic [11:0]     csr_addr_q;
   logic [XLEN-1:0] src_q;
   logic            src_zero_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] rd_data;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;

   logic [XLEN-1:0] alu_old;
   logic [XLEN-1:0] alu_new;
   logic            wen;
   logic [11:0]     addr;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] cause_val;

   ysyx_24110006_csr_alu #(.XLEN(XLEN)) u_csr_alu (
      .op      (op_q),
      .old_val (alu_old),
      .src     (src_q),
      .new_val (alu_new)
   );

   assign cause_val = (op_q == OP_EBREAK) ? XLEN'(CAUSE_BREAKPOINT) : XLEN'(CAUSE_ECALL_M);

   // CSR port decode. The old value for csr ops was captured in RD (held in
   // rd_data); mstatus is read and rewritten within STAT using the
   // combinational read port.
   always_comb begin
      wen     = 1'b0;
      addr    = '0;
      wdata   = '0;
      alu_old = rd_data;
      case (state)
         S_RD: addr = csr_addr_q;
         S_WR: begin
            wen   = 1'b1;
            addr  = csr_addr_q;
            wdata = alu_new;
         end
         S_EPC: begin
            wen   = 1'b1;
            addr  = CSR_MEPC;
            wdata = pc_q;
         end
         S_CAUSE: begin
            wen   = 1'b1;
            addr  = CSR_MCAUSE;
            wdata = cause_val;
         end
         S_STAT: begin
            wen     = 1'b1;
            addr    = CSR_MSTATUS;
            alu_old = i_csr_rdata;
            wdata   = alu_new;
         end
         S_VEC: addr = (op_q == OP_MRET) ? CSR_MEPC : CSR_MTVEC;
         default: begin
            wen   = 1'b0;
            addr  = '0;
            wdata = '0;
         end
      endcase
   end

   // A reset arriving mid-sequence must not let the pending write land.
   assign o_csr_wen   = wen & ~i_reset;
   assign o_csr_addr  = addr;
   assign o_csr_wdata = wdata;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state       <= S_IDLE;
         op_q        <= '0;
         csr_addr_q  <= '0;
         src_q       <= '0;
         src_zero_q  <= 1'b0;
         pc_q        <= '0;
         rd_data     <= '0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_valid) begin
                  op_q        <= i_op;
                  csr_addr_q  <= i_csr_addr;
                  src_q       <= i_src;
                  src_zero_q  <= i_src_zero;
                  pc_q        <= i_pc;
                  rd_data     <= '0;
                  redirect    <= 1'b0;
                  redirect_pc <= '0;
                  case (i_op)
                     OP_CSRRW, OP_CSRRS, OP_CSRRC: state <= S_RD;
                     OP_ECALL, OP_EBREAK:          state <= S_EPC;
                     OP_MRET:                      state <= S_STAT;
                     default:                      state <= S_RESP;
                  endcase
               end
            end
            S_RD: begin
               rd_data <= i_csr_rdata;
               // Set/clear with a zero operand must not write (side effects).
               if (((op_q == OP_CSRRS) || (op_q == OP_CSRRC)) && src_zero_q)
                  state <= S_RESP;
               else
                  state <= S_WR;
            end
            S_WR:    state <= S_RESP;
            S_EPC:   state <= S_CAUSE;
            S_CAUSE: state <= S_STAT;
            S_STAT:  state <= S_VEC;
            S_VEC: begin
               redirect    <= 1'b1;
               redirect_pc <= (op_q == OP_MRET) ? i_csr_rdata : (i_csr_rdata & MTVEC_MASK);
               state       <= S_RESP;
            end
            S_RESP: begin
               if (i_resp_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign o_ready       = (state == S_IDLE);
   assign o_resp_valid  = (state == S_RESP);
   assign o_rd_data     = rd_data;
   assign o_redirect    = redirect;
   assign o_redirect_pc = redirect_pc;

endmodule : ysyx_24110006_trap_unit
`default_nettype wire
